enigma_feeder: RTL and testbench
================================

ENIGMA_FEEDER -- requirements
Module: enigma_feeder

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 8, symbol buffer depth; legal values 2, 4, 8, 16.
REQ-002 SHALL provide port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port ascii_i  input  8  incoming character byte.
REQ-005 SHALL provide port ascii_valid_i  input  1  ascii_i holds a character this cycle.
REQ-006 SHALL provide port ascii_ready_o  output  1  block accepts a character this cycle.
REQ-007 SHALL provide port hold_i  input  1  high pauses symbol issue to the cipher core.
REQ-008 SHALL provide port flush_i  input  1  high discards all buffered symbols.
REQ-009 SHALL provide port symb_o  output  7  letter serial number 1..26 to the cipher core; 0 means no symbol.
REQ-010 SHALL provide port level_o  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 SHALL provide port symb_cnt_o  output  16  count of symbols issued on symb_o.
REQ-012 SHALL provide port drop_cnt_o  output  8  count of accepted characters discarded as non-letters.

Function
REQ-013 SHALL assert ascii_ready_o combinationally when rst_i is high and level_o < FIFO_DEPTH, independent of same-cycle pop.
REQ-014 SHALL accept a character on a rising edge where ascii_valid_i and ascii_ready_o are both high.
REQ-015 SHALL convert an accepted 8'h41..8'h5A ('A'..'Z') to ascii_i - 8'h40 (1..26) and push it to the FIFO tail.
REQ-016 SHALL discard any other accepted byte without FIFO write and increment drop_cnt_o, saturating at 255.
REQ-017 SHALL, each rising edge with hold_i low, flush_i low and FIFO non-empty, register the FIFO head into symb_o and pop it.
REQ-018 SHALL otherwise register 7'd0 into symb_o, so each symbol appears on symb_o for exactly one cycle.
REQ-019 SHALL provide no push-to-output bypass: character accepted at edge N appears on symb_o no earlier than after edge N+1.
REQ-020 SHALL preserve symbol order (first in, first out) with no loss or duplication.
REQ-021 SHALL allow push and pop on the same edge; level_o then remains unchanged.
REQ-022 SHALL, with flush_i high at an edge, empty the FIFO, drive symb_o to 0, and ignore any same-edge push (the handshake still completes and the byte is lost, drop_cnt_o unchanged).
REQ-023 SHALL increment symb_cnt_o on every edge that loads a non-zero symb_o, wrapping 65535 -> 0.
REQ-024 SHALL implement FIFO pointers as wrap-around modulo FIFO_DEPTH counters, with full/empty derived from level_o.

Reset
REQ-025 SHALL, while rst_i is low, force symb_o=0, level_o=0, symb_cnt_o=0, drop_cnt_o=0, ascii_ready_o=0, and both FIFO pointers to 0.
REQ-026 SHALL, on reset assertion mid-operation, discard all buffered symbols immediately without issuing them.

Configuration
REQ-027 SHALL, when macro ENIGMA_FEEDER_LOWERCASE_EN is defined, also accept 8'h61..8'h7A ('a'..'z') as letters, mapped to ascii_i - 8'h60 (1..26).
REQ-028 SHALL, when ENIGMA_FEEDER_LOWERCASE_EN is undefined, treat 8'h61..8'h7A as non-letters per REQ-016.

Verification
REQ-029 SHALL cover: reset release, push 'H','I' on consecutive cycles, hold_i=0 -> symb_o = 8 then 9 on consecutive cycles, then 0; symb_cnt_o=2.
REQ-030 SHALL cover: hold_i=1, push 8 letters 'A'..'H' then a 9th -> level_o=8, ascii_ready_o=0, 9th not accepted; release hold -> symb_o = 1..8 in order over 8 cycles.
REQ-031 SHALL cover: push '7', ' ', 'Z' -> drop_cnt_o=2, only symb_o=26 issued; 260 non-letters -> drop_cnt_o stays 255.
REQ-032 SHALL cover: FIFO holding 3 symbols, flush_i=1 one cycle with concurrent valid 'Q' -> level_o=0, symb_o=0, no 17 ever issued.
REQ-033 SHALL cover: 'a' pushed -> symb_o=1 with ENIGMA_FEEDER_LOWERCASE_EN defined; drop_cnt_o=1 and no symbol without it.
REQ-034 SHALL cover: rst_i low for one cycle mid-stream with level_o=5 -> all outputs 0 and no buffered symbol issued after release.

Source files
------------

// File: rtl/enigma_feeder.sv
// ASCII-to-letter feeder for an Enigma cipher core: buffers letters 1..26 in a FIFO
// and issues one symbol per cycle. Define ENIGMA_FEEDER_LOWERCASE_EN to accept 'a'..'z'.
module enigma_feeder #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  ascii_i,
  input  logic        ascii_valid_i,
  output logic        ascii_ready_o,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic [6:0]  symb_o,
  output logic [4:0]  level_o,
  output logic [15:0] symb_cnt_o,
  output logic [7:0]  drop_cnt_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

  logic [6:0]    mem_q [FIFO_DEPTH];
  logic [6:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [6:0]    symb_q, symb_d;
  logic [15:0]   symb_cnt_q, symb_cnt_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic       is_letter_s;
  logic [6:0] letter_s;
  logic       ready_s;
  logic       accept_s;
  logic       push_s;
  logic       pop_s;

  // Letter decode of the incoming byte
  always_comb begin
    is_letter_s = 1'b0;
    letter_s    = 7'd0;
    if ((ascii_i >= 8'h41) && (ascii_i <= 8'h5A)) begin
      is_letter_s = 1'b1;
      letter_s    = ascii_i[6:0] - 7'h40;
    end
`ifdef ENIGMA_FEEDER_LOWERCASE_EN
    else if ((ascii_i >= 8'h61) && (ascii_i <= 8'h7A)) begin
      is_letter_s = 1'b1;
      letter_s    = ascii_i[6:0] - 7'h60;
    end
`endif
    else begin
      is_letter_s = 1'b0;
      letter_s    = 7'd0;
    end
  end

  // Ready depends only on occupancy so a full FIFO never relies on a same-edge pop
  always_comb begin
    ready_s  = rst_i && (level_q < DEPTH_L);
    accept_s = ascii_valid_i && ready_s;
    push_s   = accept_s && is_letter_s && !flush_i;
    pop_s    = !hold_i && !flush_i && (level_q != 5'd0);
  end

  // FIFO, output register and counter next-state
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    symb_d     = pop_s ? mem_q[rd_ptr_q] : 7'd0;
    symb_cnt_d = pop_s ? (symb_cnt_q + 16'd1) : symb_cnt_q;

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = 5'd0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = letter_s;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + 5'd1;
        2'b01:   level_d = level_q - 5'd1;
        default: level_d = level_q;
      endcase
      if (accept_s && !is_letter_s && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_q      <= '{default: 7'd0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      symb_q     <= 7'd0;
      symb_cnt_q <= 16'd0;
      drop_cnt_q <= 8'd0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      symb_q     <= symb_d;
      symb_cnt_q <= symb_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ascii_ready_o = ready_s;
  assign symb_o        = symb_q;
  assign level_o       = level_q;
  assign symb_cnt_o    = symb_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_enigma_feeder.sv
// Scoreboard bench for enigma_feeder: directed vectors push expected symbols into a
// queue; a negedge monitor pops and compares every non-zero symb_o.
module tb_enigma_feeder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  ascii_i;
  logic        ascii_valid_i;
  logic        ascii_ready_o;
  logic        hold_i;
  logic        flush_i;
  logic [6:0]  symb_o;
  logic [4:0]  level_o;
  logic [15:0] symb_cnt_o;
  logic [7:0]  drop_cnt_o;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_symb = 0;
  int exp_drop = 0;

  enigma_feeder #(.FIFO_DEPTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ascii_i(ascii_i), .ascii_valid_i(ascii_valid_i),
    .ascii_ready_o(ascii_ready_o), .hold_i(hold_i), .flush_i(flush_i), .symb_o(symb_o),
    .level_o(level_o), .symb_cnt_o(symb_cnt_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    ascii_i       = c;
    ascii_valid_i = 1'b1;
    tick();
    ascii_valid_i = 1'b0;
  endtask

  task automatic expect_symb(input int v);
    exp_q.push_back(v);
    exp_symb++;
  endtask

  // Monitor: every issued symbol must match the head of the scoreboard
  always @(negedge clk_i) begin
    if (symb_o != 7'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_symb: got %0d expected none", symb_o);
      end else begin
        chk("symb_order", int'(symb_o), exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0; ascii_i = 8'h00; ascii_valid_i = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    repeat (3) tick();
    chk("rst_symb", int'(symb_o), 0);
    chk("rst_level", int'(level_o), 0);
    chk("rst_ready", int'(ascii_ready_o), 0);
    chk("rst_symb_cnt", int'(symb_cnt_o), 0);
    chk("rst_drop_cnt", int'(drop_cnt_o), 0);
    rst_i = 1'b1;
    #1;
    chk("ready_after_rst", int'(ascii_ready_o), 1);

    // 'H','I' back to back, no hold
    expect_symb(8); expect_symb(9);
    send(8'h48);
    chk("no_bypass_symb", int'(symb_o), 0);
    chk("level_after_h", int'(level_o), 1);
    send(8'h49);
    chk("push_pop_level", int'(level_o), 1);
    repeat (3) tick();
    chk("hi_symb_cnt", int'(symb_cnt_o), 2);
    chk("hi_level", int'(level_o), 0);

    // Lowercase 'a'
`ifdef ENIGMA_FEEDER_LOWERCASE_EN
    expect_symb(1);
`else
    exp_drop++;
`endif
    send(8'h61);
    repeat (3) tick();
    chk("lower_drop", int'(drop_cnt_o), exp_drop);
    chk("lower_symb_cnt", int'(symb_cnt_o), exp_symb);

    // Fill under hold, 9th rejected, then drain in order
    hold_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'h41 + 8'(i));
      expect_symb(i + 1);
    end
    chk("full_level", int'(level_o), 8);
    chk("full_ready", int'(ascii_ready_o), 0);
    send(8'h49);
    chk("ninth_rejected_level", int'(level_o), 8);
    hold_i = 1'b0;
    repeat (8) tick();
    chk("drain_level", int'(level_o), 0);
    chk("drain_symb_cnt", int'(symb_cnt_o), exp_symb);

    // Non-letters dropped, drop counter saturates
    send(8'h37); send(8'h20); send(8'h5A);
    expect_symb(26);
    exp_drop += 2;
    repeat (3) tick();
    chk("drop_two", int'(drop_cnt_o), exp_drop);
    for (int i = 0; i < 260; i++) send(8'(i % 64));
    exp_drop = (exp_drop + 260 > 255) ? 255 : exp_drop + 260;
    tick();
    chk("drop_saturate", int'(drop_cnt_o), exp_drop);

    // Flush with 3 buffered symbols and a concurrent 'Q'
    hold_i = 1'b1;
    send(8'h42); send(8'h43); send(8'h44);
    chk("preflush_level", int'(level_o), 3);
    flush_i = 1'b1; ascii_i = 8'h51; ascii_valid_i = 1'b1;
    #1;
    chk("flush_ready", int'(ascii_ready_o), 1);
    tick();
    ascii_valid_i = 1'b0; flush_i = 1'b0;
    chk("flush_level", int'(level_o), 0);
    chk("flush_symb", int'(symb_o), 0);
    chk("flush_drop", int'(drop_cnt_o), exp_drop);
    hold_i = 1'b0;
    repeat (5) tick();
    chk("flush_symb_cnt", int'(symb_cnt_o), exp_symb);

    // Mid-stream reset with 5 buffered symbols
    hold_i = 1'b1;
    send(8'h4A); send(8'h4B); send(8'h4C); send(8'h4D); send(8'h4E);
    chk("prereset_level", int'(level_o), 5);
    rst_i = 1'b0;
    #2;
    chk("midrst_symb", int'(symb_o), 0);
    chk("midrst_level", int'(level_o), 0);
    chk("midrst_ready", int'(ascii_ready_o), 0);
    chk("midrst_symb_cnt", int'(symb_cnt_o), 0);
    chk("midrst_drop_cnt", int'(drop_cnt_o), 0);
    tick();
    rst_i = 1'b1;
    exp_symb = 0; exp_drop = 0;
    hold_i = 1'b0;
    repeat (6) tick();
    chk("postrst_level", int'(level_o), 0);
    chk("postrst_symb_cnt", int'(symb_cnt_o), exp_symb);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
